// File: rtl/bus_arb_pkg.sv
// Shared types, default sizes and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF  = 32;
    localparam int IDX_W_DEF    = 5;
    localparam int MAX_HOLD_DEF = 8;

    // OR-reduction of indices: exact for one-hot input, zero for all-zero input.
    function automatic logic [IDX_W_DEF-1:0] onehot_to_idx(input logic [NUM_REQ_DEF-1:0] oh);
        logic [IDX_W_DEF-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ_DEF; i++) begin
            if (oh[i]) idx = idx | IDX_W_DEF'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational circular priority picker: first set request at or above i_ptr, wrapping to bit 0.
module rr_priority_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] k;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_pick  = '0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, i_ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
            k = sum[IDX_W-1:0];
            if (!o_found && i_req[k]) begin
                o_found  = 1'b1;
                o_pick[k] = 1'b1;
                o_idx    = k;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with registered one-hot grant and binary grant index.
// Optional owner hold timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int IDX_W    = IDX_W_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               arb_en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

    if (IDX_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 32 || MAX_HOLD < 1) begin : g_bad_param
        $error("bus_arbiter_rr: illegal parameter combination");
    end

    arb_state_e         r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_grant_valid;
    logic [IDX_W-1:0]   r_grant_idx;

    logic [IDX_W-1:0]   w_owner;
    logic [IDX_W-1:0]   w_owner_nxt;
    logic               w_owner_req;
    logic [NUM_REQ-1:0] w_others;
    logic [IDX_W-1:0]   w_base;
    logic [NUM_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_found;
    logic               w_timeout;
    logic               w_drop;
    logic               w_preempt;
    logic               w_take;

    assign w_owner     = IDX_W'(onehot_to_idx(NUM_REQ_DEF'(r_grant)));
    assign w_owner_nxt = (w_owner == IDX_W'(NUM_REQ-1)) ? '0 : w_owner + IDX_W'(1);
    assign w_owner_req = |(req & r_grant);
    assign w_others    = req & ~r_grant;
    // While owned, the scan already starts past the owner, matching the ptr value written on release.
    assign w_base      = (r_state == ARB_OWNED) ? w_owner_nxt : r_ptr;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (w_others),
        .i_ptr   (w_base),
        .o_pick  (w_pick),
        .o_idx   (w_pick_idx),
        .o_found (w_found)
    );

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_hold_max;

    assign w_hold_max = (r_hold_cnt == HOLD_W'(MAX_HOLD-1));
    assign w_timeout  = w_hold_max && (|w_others);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_hold_cnt <= '0;
        end else if (w_take) begin
            r_hold_cnt <= '0;
        end else if (r_state == ARB_OWNED && !w_hold_max) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_drop    = (r_state == ARB_OWNED) && !w_owner_req;
    assign w_preempt = (r_state == ARB_OWNED) && w_owner_req && w_timeout && arb_en;
    assign w_take    = arb_en && w_found && ((r_state == ARB_IDLE) || w_drop || w_preempt);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state       <= ARB_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
        end else begin
            if (w_drop || w_preempt) r_ptr <= w_owner_nxt;

            if (w_take) begin
                r_state       <= ARB_OWNED;
                r_grant       <= w_pick;
                r_grant_valid <= 1'b1;
                r_grant_idx   <= w_pick_idx;
            end else if (w_drop) begin
                r_state       <= ARB_IDLE;
                r_grant       <= '0;
                r_grant_valid <= 1'b0;
                r_grant_idx   <= '0;
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed self-checking bench for bus_arbiter_rr (32 requesters, MAX_HOLD=4).
module tb_bus_arbiter_rr;

    logic        clk;
    logic        clr_n;
    logic        arb_en;
    logic [31:0] req;
    logic [31:0] grant;
    logic        grant_valid;
    logic [4:0]  grant_idx;

    int total = 0;
    int bad   = 0;

    bus_arbiter_rr #(
        .NUM_REQ  (32),
        .IDX_W    (5),
        .MAX_HOLD (4)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .arb_en      (arb_en),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] exp_grant,
                             input logic [4:0] exp_idx, input logic exp_valid);
        check({tag, ".grant"}, grant, exp_grant);
        check({tag, ".idx"},   32'(grant_idx), 32'(exp_idx));
        check({tag, ".valid"}, 32'(grant_valid), 32'(exp_valid));
    endtask

    initial begin
        logic [4:0] exp_idx;

        // Reset with every request asserted
        clr_n  = 1'b0;
        arb_en = 1'b1;
        req    = 32'hFFFF_FFFF;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("reset", 32'h0, 5'd0, 1'b0);
        end

        // Single requester
        clr_n = 1'b1;
        req   = 32'h0000_0010;
        tick();
        check_out("single_grant", 32'h10, 5'd4, 1'b1);
        tick();
        check_out("single_hold", 32'h10, 5'd4, 1'b1);
        req = 32'h0;
        tick();
        check_out("single_drop", 32'h0, 5'd0, 1'b0);

        // Wrap: ptr=5, only bit 31 requests
        req = 32'h8000_0000;
        tick();
        check_out("wrap_31", 32'h8000_0000, 5'd31, 1'b1);
        req = 32'h0000_0001;
        tick();
        check_out("wrap_b2b_0", 32'h0000_0001, 5'd0, 1'b1);
        req = 32'h8000_0001;
        tick();
        check_out("wrap_hold_0", 32'h0000_0001, 5'd0, 1'b1);
        req = 32'h8000_0000;
        tick();
        check_out("wrap_back_31", 32'h8000_0000, 5'd31, 1'b1);
        req = 32'h0000_0006;
        tick();
        check_out("rot_1", 32'h0000_0002, 5'd1, 1'b1);
        req = 32'h0000_0004;
        tick();
        check_out("rot_2", 32'h0000_0004, 5'd2, 1'b1);
        req = 32'h0;
        tick();
        check_out("rot_idle", 32'h0, 5'd0, 1'b0);

        // Gating
        arb_en = 1'b0;
        req    = 32'h0000_0004;
        tick();
        check_out("gate_idle1", 32'h0, 5'd0, 1'b0);
        tick();
        check_out("gate_idle2", 32'h0, 5'd0, 1'b0);
        arb_en = 1'b1;
        tick();
        check_out("gate_open", 32'h4, 5'd2, 1'b1);
        arb_en = 1'b0;
        req    = 32'h0000_000C;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("gate_keep", 32'h4, 5'd2, 1'b1);
        end
        req = 32'h0000_0008;
        tick();
        check_out("gate_release", 32'h0, 5'd0, 1'b0);
        arb_en = 1'b1;
        tick();
        check_out("gate_pending", 32'h8, 5'd3, 1'b1);
        req = 32'h0;
        tick();
        check_out("gate_idle3", 32'h0, 5'd0, 1'b0);

        // Two constant requesters: timeout alternates every 4 cycles, otherwise idx 0 holds
        req = 32'h0000_0003;
        for (int n = 1; n <= 12; n++) begin
            tick();
`ifdef BUS_ARB_TIMEOUT_EN
            exp_idx = 5'(((n - 1) / 4) % 2);
`else
            exp_idx = 5'd0;
`endif
            check_out($sformatf("hold_%0d", n), 32'h1 << exp_idx, exp_idx, 1'b1);
        end
        req = 32'h0;
        tick();
        check_out("hold_idle", 32'h0, 5'd0, 1'b0);

        // Reset mid-grant clears ptr
        req = 32'h0000_0080;
        tick();
        check_out("mid_own7", 32'h80, 5'd7, 1'b1);
        clr_n = 1'b0;
        tick();
        check_out("mid_reset", 32'h0, 5'd0, 1'b0);
        clr_n = 1'b1;
        req   = 32'h0000_0081;
        tick();
        check_out("mid_ptr0", 32'h1, 5'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
